// File: rtl/mul_norm_pkg.sv
// Shared helpers for the multiplier mantissa normaliser.
// Latency: n/a (compile-time functions only).
// Backpressure: n/a.
package mul_norm_pkg;

    // Width of a leading-zero count that can express 0..width inclusive.
    function automatic int lzc_w(input int width);
        return $clog2(width + 1);
    endfunction

    // Number of register ranks when every reg_every shift levels get a rank;
    // a trailing partial group still gets its own rank.
    function automatic int ranks(input int lvls, input int reg_every);
        return (lvls + reg_every - 1) / reg_every;
    endfunction

endpackage

// File: rtl/mul_norm_stage.sv
// One rank of the normaliser: NLV binary shift levels followed by a valid/payload register.
// Latency: 1 cycle from in handshake to out_valid.
// Backpressure: in_ready = !out_valid || out_ready, purely combinational, no skid storage.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake
//   in_data, in_lzc     operand and partial count entering this rank's levels
//   lvl_data, lvl_lzc   combinational result of this rank's levels (pre-register)
//   pay_in              payload to capture on handshake (built by the parent from lvl_*)
//   out_valid/out_ready downstream handshake
//   pay_out             registered payload
module mul_norm_stage #(
    parameter int PW    = 32,
    parameter int LVLS  = 5,
    parameter int HI    = 4,   // highest shift level handled here (shift of 2**HI)
    parameter int NLV   = 2,   // number of levels handled here: HI down to HI-NLV+1
    parameter int PAY_W = 38
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PW-1:0]    in_data,
    input  logic [LVLS-1:0]  in_lzc,
    output logic [PW-1:0]    lvl_data,
    output logic [LVLS-1:0]  lvl_lzc,
    input  logic [PAY_W-1:0] pay_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PAY_W-1:0] pay_out
);

    logic [PW-1:0]   d [NLV+1];
    logic [LVLS-1:0] l [NLV+1];

    assign d[0] = in_data;
    assign l[0] = in_lzc;

    for (genvar g = 0; g < NLV; g++) begin : g_lvl
        localparam int K  = HI - g;
        localparam int SH = 1 << K;
        logic hit;
        // Top SH bits all clear: the leading one lies further down, so shift by SH.
        assign hit      = ~|d[g][PW-1 -: SH];
        assign d[g+1]   = hit ? (d[g] << SH) : d[g];
        assign l[g+1]   = l[g] | ({LVLS{hit}} & LVLS'(SH));
    end

    assign lvl_data = d[NLV];
    assign lvl_lzc  = l[NLV];

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            pay_out   <= '0;
        end else begin
            if (in_ready) out_valid <= in_valid;
            if (in_valid && in_ready) pay_out <= pay_in;
        end
    end

endmodule

// File: rtl/mul_norm_pipe.sv
// Pipelined leading-zero count and left-normalise of a WIDTH-bit mantissa product.
// Latency: ranks($clog2(WIDTH), REG_EVERY) cycles, throughput one operand per cycle.
// Backpressure: valid/ready per rank, ready chained combinationally from out_ready; stalled ranks hold.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake; in_data operand, in_exp exponent
//   out_valid/out_ready  result handshake
//   out_data             in_data shifted left by out_lzc
//   out_lzc              leading-zero count 0..WIDTH (WIDTH for an all-zero operand)
//   out_zero             operand was all zeros
//   out_exp, out_uflow   in_exp - lzc (mod 2**EXP_W) and lzc > in_exp
// Optional feature macro MUL_NORM_EXP_EN: when defined, in_exp/out_exp/out_uflow exist and the
// exponent is carried through the ranks and adjusted in the last rank before its register.
module mul_norm_pipe
    import mul_norm_pkg::*;
#(
    parameter int WIDTH     = 24,
    parameter int REG_EVERY = 2,
    parameter int EXP_W     = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
`ifdef MUL_NORM_EXP_EN
    input  logic [EXP_W-1:0]         in_exp,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [lzc_w(WIDTH)-1:0]  out_lzc,
    output logic                     out_zero
`ifdef MUL_NORM_EXP_EN
    ,
    output logic [EXP_W-1:0]         out_exp,
    output logic                     out_uflow
`endif
);

    localparam int LVLS  = $clog2(WIDTH);
    localparam int PW    = 1 << LVLS;
    localparam int LW    = lzc_w(WIDTH);
    localparam int RANKS = ranks(LVLS, REG_EVERY);

    // Per-rank payload. lzc holds the raw shift count; the all-zero clamp is applied at the output.
    typedef struct packed {
        logic [PW-1:0]    data;
        logic [LVLS-1:0]  lzc;
        logic             zero;
`ifdef MUL_NORM_EXP_EN
        logic             uflow;
        logic [EXP_W-1:0] exp;
`endif
    } pay_t;

    localparam int PAY_W = $bits(pay_t);

    pay_t           pay_q [RANKS+1];
    pay_t           pay_src;
    logic [RANKS:0] vld;
    logic [RANKS:0] rdy;

    // Operand is left-aligned in a power-of-two field so every level tests a full 2**k slice.
    always_comb begin
        pay_src      = '0;
        pay_src.data = PW'(in_data) << (PW - WIDTH);
        pay_src.zero = (in_data == '0);
`ifdef MUL_NORM_EXP_EN
        pay_src.exp  = in_exp;
`endif
    end

    assign pay_q[0]   = pay_src;
    assign vld[0]     = in_valid;
    assign in_ready   = rdy[0];
    assign rdy[RANKS] = out_ready;
    assign out_valid  = vld[RANKS];

`ifdef MUL_NORM_EXP_EN
    localparam int CW = ((LVLS > EXP_W) ? LVLS : EXP_W) + 1;
`else
    localparam int unused_exp_w = EXP_W;
`endif

    for (genvar r = 0; r < RANKS; r++) begin : g_rank
        localparam int LEFT = LVLS - r * REG_EVERY;
        localparam int HI   = LEFT - 1;
        localparam int NLV  = (LEFT < REG_EVERY) ? LEFT : REG_EVERY;

        logic [PW-1:0]   lvl_data;
        logic [LVLS-1:0] lvl_lzc;
        pay_t            nxt;

        always_comb begin
            nxt      = pay_q[r];
            nxt.data = lvl_data;
            nxt.lzc  = lvl_lzc;
`ifdef MUL_NORM_EXP_EN
            // Last rank: full count is known here. A zero operand keeps its exponent.
            if (r == RANKS - 1 && !pay_q[r].zero) begin
                nxt.uflow = CW'(lvl_lzc) > CW'(pay_q[r].exp);
                nxt.exp   = pay_q[r].exp - EXP_W'(lvl_lzc);
            end
`endif
        end

        mul_norm_stage #(
            .PW    (PW),
            .LVLS  (LVLS),
            .HI    (HI),
            .NLV   (NLV),
            .PAY_W (PAY_W)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (vld[r]),
            .in_ready  (rdy[r]),
            .in_data   (pay_q[r].data),
            .in_lzc    (pay_q[r].lzc),
            .lvl_data  (lvl_data),
            .lvl_lzc   (lvl_lzc),
            .pay_in    (nxt),
            .out_valid (vld[r+1]),
            .out_ready (rdy[r+1]),
            .pay_out   (pay_q[r+1])
        );
    end

    // Bits below the operand field only ever hold the zero padding.
    if (PW > WIDTH) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^pay_q[RANKS].data[PW-WIDTH-1:0];
    end

    assign out_data = pay_q[RANKS].data[PW-1 -: WIDTH];
    // An all-zero operand drives every level, leaving PW-1 in lzc; report WIDTH instead.
    assign out_lzc  = pay_q[RANKS].zero ? LW'(WIDTH) : LW'(pay_q[RANKS].lzc);
    assign out_zero = pay_q[RANKS].zero;
`ifdef MUL_NORM_EXP_EN
    assign out_exp   = pay_q[RANKS].exp;
    assign out_uflow = pay_q[RANKS].uflow;
`endif

endmodule
